// File: rtl/event_encoder_8_3_pkg.sv
// Shared constants and types for the 8-line event encoder and its 3-to-8 decoder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package event_encoder_8_3_pkg;

  localparam int EVT_LINES = 8;
  localparam int CODE_W    = 3;

  typedef logic [EVT_LINES-1:0] evt_vec_t;
  typedef logic [CODE_W-1:0]    evt_code_t;

  // Arbitration mode for picking among simultaneously pending lines.
  typedef enum logic {
    ARB_FIXED = 1'b0,  // lowest index wins
    ARB_RR    = 1'b1   // scan starts just after the last granted index
  } arb_mode_e;

  // Output register occupancy; FULL encodes as 1 so it doubles as out_valid.
  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } out_state_e;

  function automatic evt_vec_t code_to_onehot(input evt_code_t code);
    return evt_vec_t'(1) << code;
  endfunction

endpackage

// File: rtl/event_encoder_8_3_if.sv
// Event-in / index-out bundle between event sources, the encoder and its consumer.
// Latency: n/a (wires only).
// Backpressure: out_valid/out_ready handshake on the index stream; evt_in has none.
// Ports: evt_in (event lines), ovf_clr (sticky overflow clear), out_ready (consumer),
//        out_code/out_valid (index stream), pend (pending status), ovf (merge flag).
interface event_encoder_8_3_if;
  import event_encoder_8_3_pkg::*;

  evt_vec_t  evt_in;
  logic      ovf_clr;
  evt_code_t out_code;
  logic      out_valid;
  logic      out_ready;
  evt_vec_t  pend;
  logic      ovf;

  // Encoder side: produces the index stream and status.
  modport master (
    input  evt_in,
    input  ovf_clr,
    input  out_ready,
    output out_code,
    output out_valid,
    output pend,
    output ovf
  );

  // Sources/consumer side.
  modport slave (
    output evt_in,
    output ovf_clr,
    output out_ready,
    input  out_code,
    input  out_valid,
    input  pend,
    input  ovf
  );

endinterface

// File: rtl/event_encoder_8_3_prio_pick_8.sv
// Rotating priority picker: first set request scanning start, start+1, ... mod 8.
// Latency: combinational.
// Backpressure: none.
// Ports: req (request vector), start (scan origin), any (some request set), idx (pick).
module event_encoder_8_3_prio_pick_8
  import event_encoder_8_3_pkg::*;
(
  input  evt_vec_t  req,
  input  evt_code_t start,
  output logic      any,
  output evt_code_t idx
);

  evt_vec_t  rot;
  evt_code_t off;

  always_comb begin
    // Rotate so that line 'start' sits at bit 0; a plain lowest-set search on
    // the rotated vector then gives the offset from start.
    rot = evt_vec_t'({req, req} >> start);
    off = '0;
    for (int i = EVT_LINES - 1; i >= 0; i--) begin
      if (rot[i]) off = evt_code_t'(i);
    end
    any = |req;
    // 3-bit add wraps mod 8, undoing the rotation.
    idx = start + off;
  end

endmodule

// File: rtl/event_encoder_8_3.sv
// Sticky 8-line event capture, emitted one index per beat over valid/ready.
// Latency: 2 cycles evt_in -> out_valid when empty; one event per cycle sustained.
// Backpressure: out_ready low holds out_code/out_valid; new events merge into pend (ovf flags repeats).
// Ports: sys_clk, sys_rst_n (async active-low), bus (event_encoder_8_3_if.master).
// Parameter RR: ARB_RR = round-robin from last grant + 1, ARB_FIXED = index 0 highest.
module event_encoder_8_3
  import event_encoder_8_3_pkg::*;
#(
  parameter arb_mode_e RR = ARB_RR
)
(
  input  logic                 sys_clk,
  input  logic                 sys_rst_n,
  event_encoder_8_3_if.master  bus
);

  out_state_e state_q, state_d;
  evt_vec_t   pend_q, pend_d, clr;
  evt_code_t  code_q, ptr_q, start, pick_idx;
  logic       pick_any, load, ovf_q, ovf_set;

  // Fixed priority is just the rotating picker anchored at line 0.
  assign start = (RR == ARB_RR) ? ptr_q : '0;

  event_encoder_8_3_prio_pick_8 u_pick (
    .req   (pend_q),
    .start (start),
    .any   (pick_any),
    .idx   (pick_idx)
  );

  // The output register takes a new event whenever it is free or being drained.
  assign load = ((state_q == ST_EMPTY) || bus.out_ready) && pick_any;

  always_comb begin
    clr     = load ? code_to_onehot(pick_idx) : '0;
    // A new event on the line being loaded re-arms it: set wins over clear.
    pend_d  = (pend_q & ~clr) | bus.evt_in;
    ovf_set = |(bus.evt_in & pend_q & ~clr);
  end

  // State register.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_EMPTY: if (pick_any) state_d = ST_FULL;
      ST_FULL:  if (bus.out_ready) state_d = pick_any ? ST_FULL : ST_EMPTY;
      default:  state_d = ST_EMPTY;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      pend_q <= '0;
      code_q <= '0;
      ptr_q  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      pend_q <= pend_d;
      if (load) begin
        code_q <= pick_idx;
        ptr_q  <= pick_idx + 3'd1;
      end
      // A fresh overflow outranks a simultaneous clear.
      if (ovf_set) begin
        ovf_q <= 1'b1;
      end else if (bus.ovf_clr) begin
        ovf_q <= 1'b0;
      end
    end
  end

  // Outputs: all straight from registers.
  always_comb begin
    bus.out_valid = (state_q == ST_FULL);
    bus.out_code  = code_q;
    bus.pend      = pend_q;
    bus.ovf       = ovf_q;
  end

endmodule

// File: tb/tb_event_encoder_8_3.sv
// Directed bench for event_encoder_8_3: a fixed-priority and a round-robin instance,
// each with its own queue of expected codes checked on every handshake.
module tb_event_encoder_8_3;
  import event_encoder_8_3_pkg::*;

  logic sys_clk;
  logic sys_rst_n;

  event_encoder_8_3_if if_fp ();
  event_encoder_8_3_if if_rr ();

  event_encoder_8_3 #(.RR(ARB_FIXED)) u_dut_fp (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .bus       (if_fp)
  );

  event_encoder_8_3 #(.RR(ARB_RR)) u_dut_rr (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .bus       (if_rr)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  int n_checks = 0;
  int n_fail   = 0;
  int beats_fp = 0;
  int beats_rr = 0;
  int b0;
  logic [2:0] q_fp[$];
  logic [2:0] q_rr[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, required %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  // Handshake monitors: inputs change just after posedge, so at negedge they
  // show exactly what the coming edge will sample.
  always @(negedge sys_clk) begin
    if (sys_rst_n && if_fp.out_valid && if_fp.out_ready) begin
      beats_fp++;
      if (q_fp.size() == 0) chk("fp_unexpected_beat", q_fp.size(), 1);
      else                  chk("fp_code", if_fp.out_code, q_fp.pop_front());
    end
    if (sys_rst_n && if_rr.out_valid && if_rr.out_ready) begin
      beats_rr++;
      if (q_rr.size() == 0) chk("rr_unexpected_beat", q_rr.size(), 1);
      else                  chk("rr_code", if_rr.out_code, q_rr.pop_front());
    end
  end

  initial begin
    sys_rst_n        = 1'b0;
    if_fp.evt_in     = '0;
    if_fp.ovf_clr    = 1'b0;
    if_fp.out_ready  = 1'b1;
    if_rr.evt_in     = '0;
    if_rr.ovf_clr    = 1'b0;
    if_rr.out_ready  = 1'b1;
    tick(3);

    // Reset state
    chk("rst_fp_valid", if_fp.out_valid, 0);
    chk("rst_fp_code",  if_fp.out_code,  0);
    chk("rst_fp_pend",  if_fp.pend,      0);
    chk("rst_fp_ovf",   if_fp.ovf,       0);
    chk("rst_rr_valid", if_rr.out_valid, 0);
    chk("rst_rr_pend",  if_rr.pend,      0);
    sys_rst_n = 1'b1;
    tick(1);

    // Single event on line 5: visible two edges later, one beat
    b0 = beats_fp;
    if_fp.evt_in = 8'h20; q_fp.push_back(3'd5);
    tick(1); if_fp.evt_in = '0;
    chk("single_pend_n1",  if_fp.pend,      8'h20);
    chk("single_valid_n1", if_fp.out_valid, 0);
    tick(1);
    chk("single_valid_n2", if_fp.out_valid, 1);
    chk("single_code_n2",  if_fp.out_code,  5);
    chk("single_pend_n2",  if_fp.pend,      0);
    tick(1);
    chk("single_valid_n3", if_fp.out_valid, 0);
    chk("single_ovf",      if_fp.ovf,       0);
    chk("single_beats",    beats_fp - b0,   1);

    // Simultaneous 0,4,7 with fixed priority, back to back
    if_fp.evt_in = 8'h91;
    q_fp.push_back(3'd0); q_fp.push_back(3'd4); q_fp.push_back(3'd7);
    tick(1); if_fp.evt_in = '0;
    tick(1); chk("fp_multi_c0", if_fp.out_code, 0); chk("fp_multi_v0", if_fp.out_valid, 1);
    tick(1); chk("fp_multi_c1", if_fp.out_code, 4);
    tick(1); chk("fp_multi_c2", if_fp.out_code, 7);
    tick(1); chk("fp_multi_vend", if_fp.out_valid, 0); chk("fp_multi_pend", if_fp.pend, 0);

    // Round robin: grant 4 first, then 0x31 resolves as 5,0,4
    if_rr.evt_in = 8'h10; q_rr.push_back(3'd4);
    tick(1); if_rr.evt_in = '0;
    tick(2);
    if_rr.evt_in = 8'h31;
    q_rr.push_back(3'd5); q_rr.push_back(3'd0); q_rr.push_back(3'd4);
    tick(1); if_rr.evt_in = '0;
    chk("rr_pend", if_rr.pend, 8'h31);
    tick(1); chk("rr_c0", if_rr.out_code, 5);
    tick(1); chk("rr_c1", if_rr.out_code, 0);
    tick(1); chk("rr_c2", if_rr.out_code, 4);
    tick(1); chk("rr_vend", if_rr.out_valid, 0);

    // Backpressure: code 1 held stable while line 2 waits
    if_fp.out_ready = 1'b0;
    if_fp.evt_in = 8'h06; q_fp.push_back(3'd1); q_fp.push_back(3'd2);
    tick(1); if_fp.evt_in = '0;
    tick(1);
    for (int i = 0; i < 10; i++) begin
      chk("bp_valid", if_fp.out_valid, 1);
      chk("bp_code",  if_fp.out_code,  1);
      chk("bp_pend",  if_fp.pend,      8'h04);
      tick(1);
    end
    if_fp.out_ready = 1'b1;
    tick(1); chk("bp_code2", if_fp.out_code, 2);
    tick(1); chk("bp_vend",  if_fp.out_valid, 0);

    // Overflow: line 3 pulsed twice while the output is blocked by code 0
    if_fp.out_ready = 1'b0;
    if_fp.evt_in = 8'h01; q_fp.push_back(3'd0);
    tick(1); if_fp.evt_in = '0;
    tick(1);
    if_fp.evt_in = 8'h08; q_fp.push_back(3'd3);
    tick(1); if_fp.evt_in = '0;
    chk("ovf_first_pulse", if_fp.ovf, 0);
    tick(1); if_fp.evt_in = 8'h08;
    tick(1); if_fp.evt_in = '0;
    chk("ovf_second_pulse", if_fp.ovf,  1);
    chk("ovf_pend_merged",  if_fp.pend, 8'h08);
    b0 = beats_fp;
    if_fp.out_ready = 1'b1;
    tick(2);
    chk("ovf_drain_valid", if_fp.out_valid, 0);
    chk("ovf_drain_beats", beats_fp - b0,   2);

    // Set wins over clear: line 3 high on its own load cycle -> delivered twice
    if_fp.evt_in = 8'h08; q_fp.push_back(3'd3); q_fp.push_back(3'd3);
    tick(2); if_fp.evt_in = '0;
    chk("sw_pend_kept", if_fp.pend,      8'h08);
    chk("sw_ovf_same",  if_fp.ovf,       1);
    chk("sw_code_a",    if_fp.out_code,  3);
    tick(1);
    chk("sw_code_b",    if_fp.out_code,  3);
    chk("sw_valid_b",   if_fp.out_valid, 1);
    chk("sw_pend_b",    if_fp.pend,      0);
    tick(1);
    chk("sw_vend",      if_fp.out_valid, 0);
    if_fp.ovf_clr = 1'b1;
    tick(1); if_fp.ovf_clr = 1'b0;
    chk("ovf_cleared", if_fp.ovf, 0);

    // Async reset with everything pending and a beat presented
    if_rr.out_ready = 1'b0;
    if_rr.evt_in = 8'hFF;
    tick(2); if_rr.evt_in = '0;
    chk("ar_pre_valid", if_rr.out_valid, 1);
    chk("ar_pre_pend",  if_rr.pend,      8'hFF);
    #2 sys_rst_n = 1'b0;
    #1;
    chk("ar_valid", if_rr.out_valid, 0);
    chk("ar_code",  if_rr.out_code,  0);
    chk("ar_pend",  if_rr.pend,      0);
    chk("ar_ovf",   if_rr.ovf,       0);
    tick(2);
    sys_rst_n = 1'b1;
    if_rr.out_ready = 1'b1;
    b0 = beats_rr;
    tick(5);
    chk("ar_idle_valid", if_rr.out_valid, 0);
    chk("ar_idle_beats", beats_rr - b0,   0);
    // Pointer restarted at 0 after reset
    if_rr.evt_in = 8'h02; q_rr.push_back(3'd1);
    tick(1); if_rr.evt_in = '0;
    tick(1); chk("ar_new_code", if_rr.out_code, 1);
    tick(1); chk("ar_new_vend", if_rr.out_valid, 0);

    chk("fp_queue_drained", q_fp.size(), 0);
    chk("rr_queue_drained", q_rr.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/event_encoder_8_3.md
# event_encoder_8_3

Sequential 8-to-3 event encoder: the return path for the 3-to-8 decoder. It captures one-hot or multi-hot event pulses on eight lines into a sticky pending register and emits them one at a time as 3-bit indices over a valid/ready stream. It sits between distributed event sources (each driving one decoder-indexed line) and a single consumer that needs the binary index of each event, without losing simultaneous events.

## Interface
- RR, 1, arbitration mode: 1 = round-robin starting after last granted index; 0 = fixed priority, index 0 highest.
- sys_clk  in  1  single clock, all state on rising edge.
- sys_rst_n  in  1  asynchronous, active-low reset.
- evt_in  in  8  event lines; any cycle with evt_in[i]=1 raises event i (level held N cycles = N events requested).
- out_code  out  3  binary index of the presented event.
- out_valid  out  1  out_code holds an event.
- out_ready  in  1  consumer accepts when out_valid && out_ready.
- pend  out  8  current pending register (status).
- ovf  out  1  sticky: an event arrived on an already-pending line and was merged.
- ovf_clr  in  1  clears ovf (one-cycle pulse).

## Operation
- Reset (async assert): pend=8'h00, out_valid=0, out_code=3'd0, ovf=0, RR pointer=3'd0.
- Pending update each cycle: pend_next[i] = (pend[i] & ~clr[i]) | evt_in[i]; clr is one-hot of the index loaded into the output register this cycle, else zero.
- Set wins over clear: event on the line being loaded this cycle stays pending (new request, no ovf).
- ovf set when evt_in[i]=1 && pend[i]=1 && !clr[i]; ovf_clr and a new overflow in the same cycle: set wins.
- Output register loads when (!out_valid || out_ready) && pend != 0: out_code = picked index, out_valid=1, clr = one-hot(pick).
- Output empties when out_valid && out_ready && pend == 0: out_valid=0, out_code holds last value.
- Pick uses pend (registered), never evt_in directly.
- RR=0: lowest set index of pend.
- RR=1: first set index scanning ptr, ptr+1, ... wrapping mod 8; on load ptr = pick+1 (7 wraps to 0). ptr unchanged when nothing loaded.
- States (implicit, out_valid): EMPTY (out_valid=0) and FULL (out_valid=1). EMPTY->FULL on pend!=0; FULL->FULL on accept with pend!=0 (back-to-back, one event per cycle); FULL->EMPTY on accept with pend==0; FULL holds while !out_ready.
- Stream rules: out_code and out_valid stable while out_valid && !out_ready; out_valid never drops without a handshake.
- Reset mid-operation: all pending and presented events discarded, no handshake completes.

## Timing
- Latency evt_in to out_valid: 2 cycles (cycle N sample -> pend at N+1 -> out_valid at N+2) when output empty and line is highest priority.
- Throughput: one event per cycle with out_ready held high.
- All outputs registered; no combinational path from evt_in or out_ready to any output.
- ovf visible the cycle after the offending evt_in.

## Structure
- Shared package: EVT_LINES=8, CODE_W=3 constants and any mode enum for RR; shared with the 3-to-8 decoder.
- One sub-module: prio_pick_8 — combinational, inputs req[7:0], start[2:0]; outputs any, idx[2:0]; RR=0 instantiates it with start=0.
- Top holds pend, output register, ptr, ovf.

## Test plan
- Single event: evt_in=8'h20 one cycle, out_ready=1 -> out_valid at +2 with out_code=5, one beat, pend back to 0, ovf=0.
- Simultaneous, RR=0: evt_in=8'h91 one cycle, out_ready=1 -> codes 0,4,7 on three consecutive cycles, then out_valid=0.
- Simultaneous, RR=1 after granting 4: pend=8'h31 -> codes 5,0,4 order (scan from 5, wrap).
- Backpressure: out_ready=0 with evt_in=8'h06 -> out_code=1 held stable for 10 cycles, pend=8'h04; raise ready -> 1 then 2 accepted.
- Overflow and set-wins: evt_in[3] pulsed twice while held by out_ready=0 -> ovf=1, single code 3 delivered; evt_in[3] on its load cycle -> code 3 delivered twice, ovf unchanged; ovf_clr -> ovf=0.
- Async reset mid-stream: sys_rst_n low with pend=8'hFF, out_valid=1 -> all outputs 0 immediately, no events delivered after release until new evt_in.
